fifo_burst_reader: RTL and testbench

- Downstream drain stage for the synchronous FIFO. Consumes the FIFO's first-word-fall-through read side (valid/data/almostempty, drives the FIFO read request).
- Emits framed bursts of BURST_LEN beats, with a last marker, to a valid/ready sink.
- A programmable idle timeout flushes residual data that never reaches a full burst.
- Integration rule: the FIFO almostempty level is tied to BURST_LEN-1, so almostempty low means at least BURST_LEN entries are stored.

---
 rtl/fifo_burst_reader.sv | 127 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Drains a FWFT FIFO into framed BURST_LEN-beat packets; idle timeout flushes leftovers as 1-beat packets.
// Latency 1 (pop -> o_valid); FIFO read request drops while an output beat is held by i_ready=0.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int TMO_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_valid,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_almostempty,
    output logic                  o_fifo_ready,
    input  logic [TMO_WIDTH-1:0]  i_timeout,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_flush
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        beat_q, beat_d;
    logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
    logic                 ae_q;
    logic                 out_free;
    logic                 pop;
    logic                 burst_rdy;
    logic                 tmo_run;
    logic                 tmo_hit;
    logic                 load_last;
    logic                 load_flush;

    assign out_free  = ~o_valid | i_ready;
    assign pop       = o_fifo_ready & i_fifo_valid;
    assign burst_rdy = i_fifo_valid & ~i_fifo_almostempty;
    // A change in the almostempty level restarts the idle count.
    assign tmo_run   = i_fifo_valid & (i_timeout != '0) & (i_fifo_almostempty == ae_q);
    assign tmo_hit   = tmo_run & (tmo_q == (i_timeout - TMO_WIDTH'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            tmo_q   <= '0;
            ae_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            ae_q    <= i_fifo_almostempty;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (burst_rdy) begin
                    state_d = S_BURST;
                end else if (tmo_run) begin
                    if (tmo_hit) state_d = S_FLUSH;
                    else         tmo_d   = tmo_q + TMO_WIDTH'(1);
                end
            end
            S_BURST: begin
                if (pop) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (~i_fifo_valid | ~i_fifo_almostempty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // In FLUSH a full burst's worth of data must not be popped as single beats.
    always_comb begin
        o_busy       = (state_q != S_IDLE);
        o_fifo_ready = 1'b0;
        load_last    = 1'b0;
        load_flush   = 1'b0;
        case (state_q)
            S_BURST: begin
                o_fifo_ready = out_free;
                load_last    = (beat_q == LAST_BEAT);
            end
            S_FLUSH: begin
                o_fifo_ready = out_free & i_fifo_almostempty;
                load_last    = 1'b1;
                load_flush   = 1'b1;
            end
            default: begin
                o_fifo_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_flush <= 1'b0;
        end else if (pop) begin
            o_valid <= 1'b1;
            o_data  <= i_fifo_data;
            o_last  <= load_last;
            o_flush <= load_flush;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: FWFT FIFO model feeds the DUT, a scoreboard checks every accepted output beat.
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_valid;
    logic [DW-1:0] fifo_data;
    logic          fifo_ae;
    logic          fifo_ready;
    logic [TW-1:0] tmo;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          rdy;
    logic          o_busy;
    logic          o_flush;
    logic          hide;

    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            cnt;
    int            cyc = 0;
    int            pop_cyc [$];
    logic [9:0]    sb [$];
    int            total = 0;
    int            bad = 0;
    int            extra = 0;

    always #5 clk = ~clk;

    assign cnt        = wr_ptr - rd_ptr;
    assign fifo_valid = (cnt != 0) && !hide;
    assign fifo_data  = mem[rd_ptr[7:0]];
    assign fifo_ae    = hide || (cnt <= BL - 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_ready && fifo_valid) begin
            rd_ptr <= rd_ptr + 1;
            pop_cyc.push_back(cyc);
        end
    end

    fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TMO_WIDTH(TW)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_fifo_valid       (fifo_valid),
        .i_fifo_data        (fifo_data),
        .i_fifo_almostempty (fifo_ae),
        .o_fifo_ready       (fifo_ready),
        .i_timeout          (tmo),
        .o_valid            (o_valid),
        .o_data             (o_data),
        .o_last             (o_last),
        .i_ready            (rdy),
        .o_busy             (o_busy),
        .o_flush            (o_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [DW-1:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr++;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l, input logic f);
        sb.push_back({l, f, d});
    endtask

    // One clock: accepted beats are checked at the negedge, inputs change at posedge+1.
    task automatic tick();
        logic [9:0] e;
        @(negedge clk);
        if (o_valid && rdy) begin
            if (sb.size() == 0) begin
                extra++;
            end else begin
                e = sb.pop_front();
                check("beat", 32'({o_last, o_flush, o_data}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
        check("no_extra_beats", 32'(extra), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        rdy  = 1'b1;
        tmo  = '0;
        hide = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({o_valid, o_data, o_last, o_flush, fifo_ready, o_busy}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two back-to-back bursts with a single idle cycle between them.
        base = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            write(8'(32'h10 + i));
            push_exp(8'(32'h10 + i), (i % 4) == 3, 1'b0);
        end
        drain(40);
        check("t1_pops", 32'(pop_cyc.size() - base), 32'd8);
        check("t1_burst_span", 32'(pop_cyc[base+3] - pop_cyc[base]), 32'd3);
        check("t1_idle_gap", 32'(pop_cyc[base+4] - pop_cyc[base+3]), 32'd2);

        // Sink backpressure mid-burst.
        base = pop_cyc.size();
        for (int i = 0; i < 4; i++) begin
            write(8'(32'h20 + i));
            push_exp(8'(32'h20 + i), i == 3, 1'b0);
        end
        n = 0;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        rdy = 1'b0;
        check("t2_first_data", 32'(o_data), 32'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", 32'(o_valid), 32'd1);
            check("t2_hold_data", 32'(o_data), 32'h20);
            check("t2_hold_fifo_ready", 32'(fifo_ready), 32'd0);
        end
        rdy = 1'b1;
        drain(20);
        check("t2_pops", 32'(pop_cyc.size() - base), 32'd4);

        // Idle timeout flush of a partial burst.
        tmo = 8'd5;
        write(8'h30);
        write(8'h31);
        push_exp(8'h30, 1'b1, 1'b1);
        push_exp(8'h31, 1'b1, 1'b1);
        repeat (4) tick();
        check("t3_not_yet_busy", 32'(o_busy), 32'd0);
        tick();
        check("t3_flush_start", 32'(o_busy), 32'd1);
        drain(20);
        tick();
        check("t3_back_idle", 32'(o_busy), 32'd0);

        // Timeout disabled: a partial burst waits until the burst fills.
        tmo  = '0;
        base = pop_cyc.size();
        for (int i = 0; i < 3; i++) write(8'(32'h40 + i));
        repeat (20) tick();
        check("t4_idle_busy", 32'(o_busy), 32'd0);
        check("t4_idle_valid", 32'(o_valid), 32'd0);
        check("t4_idle_pops", 32'(pop_cyc.size() - base), 32'd0);
        write(8'h43);
        for (int i = 0; i < 4; i++) push_exp(8'(32'h40 + i), i == 3, 1'b0);
        drain(20);

        // FIFO runs dry after two pops of a burst.
        base = pop_cyc.size();
        for (int i = 0; i < 4; i++) begin
            write(8'(32'h50 + i));
            push_exp(8'(32'h50 + i), i == 3, 1'b0);
        end
        n = 0;
        while ((pop_cyc.size() - base) < 2 && n < 20) begin
            tick();
            n++;
        end
        hide = 1'b1;
        check("t5_two_pops", 32'(pop_cyc.size() - base), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_stall_busy", 32'(o_busy), 32'd1);
            check("t5_stall_pops", 32'(pop_cyc.size() - base), 32'd2);
        end
        hide = 1'b0;
        drain(20);
        check("t5_pops", 32'(pop_cyc.size() - base), 32'd4);

        // Reset with a beat held in the output register.
        rdy  = 1'b0;
        base = pop_cyc.size();
        for (int i = 0; i < 4; i++) write(8'(32'h60 + i));
        n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        check("t6_valid_before_rst", 32'(o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", 32'({o_valid, o_data, o_last, o_flush, fifo_ready, o_busy}), 32'd0);
        write(8'h64);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i < 5; i++) push_exp(8'(32'h60 + i), i == 4, 1'b0);
        rdy = 1'b1;
        drain(30);
        check("t6_pops", 32'(pop_cyc.size() - base), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
